mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares one single-ported memory between the core's instruction fetch and its load/store path. It sits between the core (fetch address/valid on one side; request/load/store/masking on the other) and the unified memory. Per transaction it latches the winning request, holds it on the memory port until the memory acknowledges, and returns a one-cycle valid pulse with read data to the winner. The data side has fixed priority.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (byte mask width is `DATA_W/8`)
- `TIMEOUT`, 255, busy cycles without `mem_ack` before abort (only with `MEM_ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request, held until `if_valid`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetched instruction
- `if_valid`  out  1  one-cycle fetch completion
- `if_err`  out  1  fetch aborted by timeout, qualified by `if_valid`
- `d_req`  in  1  data request (load or store), held until `d_valid`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_mask`  in  DATA_W/8  byte enables
- `d_rdata`  out  DATA_W  load data
- `d_valid`  out  1  one-cycle data completion
- `d_err`  out  1  data access aborted by timeout, qualified by `d_valid`
- `mem_req`  out  1  memory request
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_mask`  out  DATA_W/8  memory byte enables
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ack`
- `mem_ack`  in  1  memory completion
- `busy`  out  1  transaction in flight (state is not IDLE)

## Operation
States:
- **IDLE**
  - If `d_req` and not `d_valid`: latch `d_we/d_addr/d_wdata/d_mask`, go to D_BUSY.
  - Else if `if_req` and not `if_valid`: latch `if_addr` with `mem_we` = 0 and `mem_mask` all-ones, go to IF_BUSY.
  - Else stay in IDLE.
- **IF_BUSY / D_BUSY**
  - `mem_req` = 1 and all `mem_*` outputs are held at the latched values.
  - Requester inputs are ignored until completion.
  - On `mem_ack`: return to IDLE. Next cycle, pulse the owner's `*_valid` for one cycle.
  - Fetch, or data read (`mem_we` = 0): register `mem_rdata` into the owner's `*_rdata`.
  - Data write: `d_rdata` is unchanged.

Rules:
- Masking: in IDLE, a requester whose `*_valid` is high that cycle is not granted. This lets the requester drop `*_req` combinationally on valid without a spurious re-grant.
- Priority: when both requests are pending in IDLE, data wins. Fetch is served next, after the data `d_valid` cycle.
- `*_rdata` holds its last value between transactions.
- `mem_ack` outside a busy state is ignored.

Reset values (all while `rst` is high):
- state = IDLE.
- All outputs are 0: `mem_*`, `*_valid`, `*_err`, `*_rdata`, `busy`.
- Latched request registers are cleared.
- Reset mid-transaction abandons it. No valid pulse is issued, and `mem_req` is 0 from the first clock edge at which `rst` is sampled high.

## Timing
- Grant edge to `mem_req`: `mem_req` is registered and rises in the cycle after IDLE samples the request.
- Minimum latency: request seen in cycle 0; `mem_req` high in cycle 1 with `mem_ack` in cycle 1; `*_valid` in cycle 2.
- Back-to-back: after a `*_valid` cycle (IDLE), the next grant happens in that same cycle. `mem_req` therefore rises at most every 2 cycles for zero-wait memory.
- `mem_*` are stable from `mem_req` rising through the `mem_ack` cycle inclusive. `mem_req` is 0 in the cycle after `mem_ack`.
- `*_valid` and `*_err` are registered and never both asserted for the two sides in the same cycle.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter clears on grant and increments each busy cycle with `mem_ack` low.
  - When the counter equals `TIMEOUT` and `mem_ack` is still low, the transaction aborts. `mem_req` drops and the state returns to IDLE.
  - The owner gets `*_valid` = 1 and `*_err` = 1 the next cycle.
  - On an aborted fetch, `if_rdata` = 32'h0000_0013 (NOP). On an aborted data read, `d_rdata` = 0.
  - `mem_ack` arriving in the same cycle as the limit wins: normal completion, `*_err` = 0.
- Not defined: no counter; the arbiter waits for `mem_ack` indefinitely; `if_err`/`d_err` are tied 0; `TIMEOUT` is unused.

## Test plan
- **Single fetch:** `if_req` with `if_addr`=0x100, zero-wait memory returning 0x00500093 → `mem_req` high in cycle 1, `if_valid` in cycle 2 with `if_rdata`=0x00500093, `busy` 1 in cycle 1 only.
- **Simultaneous requests:** `if_req` and a `d_req` load at 0x2000 in the same cycle, memory returning 0xDEADBEEF → data is served first (`d_valid` cycle 2, `d_rdata`=0xDEADBEEF); fetch is granted in cycle 2, with `mem_req` at `mem_addr`=0x100 in cycle 3 and `if_valid` in cycle 4.
- **Store with wait states:** `d_we`=1, `d_addr`=0x40, `d_mask`=4'b0011, `d_wdata`=0x1234ABCD, `mem_ack` delayed 3 cycles → `mem_*` are stable for all 4 request cycles, one `d_valid` pulse, `d_rdata` unchanged.
- **Masking:** requester keeps `d_req` high during its `d_valid` cycle → no second grant; `mem_req` stays 0 the following cycle.
- **Reset mid-transaction:** `rst` asserted in the second wait cycle of a fetch → `mem_req` 0 on the next cycle, no `if_valid`, all outputs 0, IDLE after `rst` releases.
- **Timeout (`MEM_ARB_TIMEOUT_EN`, `TIMEOUT`=4):** fetch with `mem_ack` never asserted → abort after 4 busy cycles; `if_valid`=1, `if_err`=1, `if_rdata`=0x00000013.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//
// Bundles every handshake and bus signal of the two-requester memory
// arbiter: the fetch port, the load/store port and the shared memory port.
//
// Modports:
//   slave  - the arbiter's view. It receives fetch/data requests and the
//            memory's response, and drives completions plus the memory request.
//   master - the surrounding system's view (core requesters + memory model).
//
// Signals:
//   if_req, if_addr            fetch request and address
//   if_rdata, if_valid, if_err fetch completion (data, one-cycle pulse, abort flag)
//   d_req, d_we, d_addr,
//   d_wdata, d_mask            data request, store select, address, data, byte enables
//   d_rdata, d_valid, d_err    data completion (load data, one-cycle pulse, abort flag)
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_mask        request held on the single-ported memory
//   mem_rdata, mem_ack         memory read data and completion
//   busy                       a transaction is in flight
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_valid;
    logic                  if_err;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_mask;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_valid;
    logic                  d_err;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_mask;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ack;

    logic                  busy;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_mask,
        input  mem_rdata, mem_ack,
        output if_rdata, if_valid, if_err,
        output d_rdata, d_valid, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_mask,
        output mem_rdata, mem_ack,
        input  if_rdata, if_valid, if_err,
        input  d_rdata, d_valid, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares one single-ported memory between the instruction fetch and the
// load/store path of a core. Each transaction latches the winning request,
// holds it on the memory port until mem_ack, then returns a registered
// one-cycle valid pulse (with read data) to the winner. Data has fixed
// priority over fetch.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width (byte mask is DATA_W/8 wide)
//   TIMEOUT  busy cycles without mem_ack before a transaction is aborted
//            (only meaningful with MEM_ARB_TIMEOUT_EN)
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   mem_arbiter_if.slave: fetch port, data port, memory port, busy
//
// Build option:
//   MEM_ARB_TIMEOUT_EN  when defined, a wait counter aborts a transaction
//                       that sees no mem_ack for TIMEOUT busy cycles and
//                       reports it through if_err / d_err. When undefined the
//                       arbiter waits forever and the error flags stay 0.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    localparam int MASK_W = DATA_W / 8;

    // Instruction returned for an aborted fetch, so the core executes a NOP.
    localparam logic [DATA_W-1:0] NOP_INSN = DATA_W'(32'h0000_0013);

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        D_BUSY
    } state_t;

    state_t state;
    state_t state_next;

    logic              grant_d;
    logic              grant_if;
    logic              done;
    logic              abort;
    logic              finish;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [MASK_W-1:0] lat_mask;

    logic [DATA_W-1:0] if_rdata_q;
    logic              if_valid_q;
    logic              if_err_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              d_valid_q;
    logic              d_err_q;

    logic              mem_req_c;
    logic              busy_c;

    // A requester whose completion pulse is high this cycle is masked, so a
    // request line that is dropped combinationally on valid is never re-granted.
    assign grant_d  = bus.d_req && !d_valid_q;
    assign grant_if = bus.if_req && !if_valid_q;

    // mem_ack only counts while a transaction is actually in flight.
    assign done   = (state != IDLE) && bus.mem_ack;
    assign finish = done || abort;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;

    assign wait_cnt_inc = wait_cnt + 1'b1;

    // The incremented count is compared so the abort lands on the TIMEOUT-th
    // busy cycle without an ack; an ack in that same cycle still wins.
    assign abort = (state != IDLE) && !bus.mem_ack && (wait_cnt_inc == CNT_W'(TIMEOUT));

    // Wait counter: held at zero in IDLE (which clears it on every grant) and
    // advanced on each busy cycle the memory leaves unacknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if (!bus.mem_ack) begin
            wait_cnt <= wait_cnt_inc;
        end
    end
`else
    assign abort = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: data wins over fetch in IDLE; busy states leave on
    // ack or abort.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = D_BUSY;
                end else if (grant_if) begin
                    state_next = IF_BUSY;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: mem_req comes straight from the state flops, so it is
    // registered and falls the cycle after ack, abort or reset.
    always_comb begin
        mem_req_c = 1'b0;
        busy_c    = 1'b0;
        case (state)
            IF_BUSY, D_BUSY: begin
                mem_req_c = 1'b1;
                busy_c    = 1'b1;
            end
            default: ;
        endcase
    end

    // Request latch: loaded only at the grant, so mem_* stay frozen for the
    // whole transaction regardless of what the requesters do meanwhile.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_mask  <= '0;
        end else if (state == IDLE) begin
            if (grant_d) begin
                lat_we    <= bus.d_we;
                lat_addr  <= bus.d_addr;
                lat_wdata <= bus.d_wdata;
                lat_mask  <= bus.d_mask;
            end else if (grant_if) begin
                lat_we    <= 1'b0;
                lat_addr  <= bus.if_addr;
                lat_wdata <= '0;
                lat_mask  <= '1;
            end
        end
    end

    // Completion: pulse the owner's valid for one cycle and capture read
    // data. Stores leave d_rdata untouched; aborts substitute NOP / zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            if_rdata_q <= '0;
            d_valid_q  <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            d_valid_q  <= 1'b0;
            d_err_q    <= 1'b0;
            if (finish) begin
                if (state == IF_BUSY) begin
                    if_valid_q <= 1'b1;
                    if_err_q   <= abort;
                    if_rdata_q <= abort ? NOP_INSN : bus.mem_rdata;
                end else if (state == D_BUSY) begin
                    d_valid_q <= 1'b1;
                    d_err_q   <= abort;
                    if (!lat_we) begin
                        d_rdata_q <= abort ? '0 : bus.mem_rdata;
                    end
                end
            end
        end
    end

    assign bus.mem_req   = mem_req_c;
    assign bus.busy      = busy_c;
    assign bus.mem_we    = lat_we;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.mem_mask  = lat_mask;

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_err    = if_err_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//
// Directed steps for the documented scenarios, then a randomized phase where
// two requesters and a wait-state memory run against a transaction-level
// reference: a reference memory image, the grant rules (data first, valid
// masking) and per-transaction expectations of the memory port.
module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference memory image and the memory model's own storage.
    logic [31:0] ref_mem [int];
    logic [31:0] ram     [int];

    // Requester-side model state.
    bit          d_pend, if_pend;
    logic        d_we_m;
    logic [31:0] d_addr_m, d_wdata_m, if_addr_m;
    logic [3:0]  d_mask_m;
    logic [31:0] last_d_rdata;

    // Expected grant for the next cycle: 0 none, 1 fetch, 2 data.
    int          exp_grant;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_mask;

    // Memory-side model state.
    bit          mem_wait_last;
    int          wait_left;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_mask;

    function automatic logic [31:0] initWord(input int idx);
        return (32'(idx) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] mergeMask(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] a);
        int idx;
        idx = int'(a[5:2]);
        if (ref_mem.exists(idx)) return ref_mem[idx];
        return initWord(idx);
    endfunction

    function automatic logic [31:0] ramLoad(input logic [31:0] a);
        int idx;
        idx = int'(a[5:2]);
        if (ram.exists(idx)) return ram[idx];
        return initWord(idx);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ifr, input logic [31:0] ifa,
                                 input logic dr, input logic dwe, input logic [31:0] da,
                                 input logic [31:0] dwd, input logic [3:0] dm,
                                 input logic ack, input logic [31:0] rd);
        bus.if_req    = ifr;
        bus.if_addr   = ifa;
        bus.d_req     = dr;
        bus.d_we      = dwe;
        bus.d_addr    = da;
        bus.d_wdata   = dwd;
        bus.d_mask    = dm;
        bus.mem_ack   = ack;
        bus.mem_rdata = rd;
        @(negedge clk);
    endtask

    task automatic randomCycle(input bit allow_new);
        bit          busy_now;
        logic        ack;
        logic [31:0] exp_rd;

        busy_now = (exp_grant != 0) || mem_wait_last;

        if (bus.d_valid) begin
            checkOutput("d_valid_owned", 64'(d_pend), 64'd1);
            checkOutput("d_err_normal", 64'(bus.d_err), 64'd0);
            checkOutput("valid_exclusive", 64'(bus.if_valid), 64'd0);
            if (d_pend) begin
                if (d_we_m) begin
                    checkOutput("d_rdata_hold", 64'(bus.d_rdata), 64'(last_d_rdata));
                    ref_mem[int'(d_addr_m[5:2])] = mergeMask(refLoad(d_addr_m), d_wdata_m, d_mask_m);
                end else begin
                    last_d_rdata = refLoad(d_addr_m);
                    checkOutput("d_rdata_load", 64'(bus.d_rdata), 64'(last_d_rdata));
                end
                d_pend = 1'b0;
            end
        end
        if (bus.if_valid) begin
            checkOutput("if_valid_owned", 64'(if_pend), 64'd1);
            checkOutput("if_err_normal", 64'(bus.if_err), 64'd0);
            if (if_pend) begin
                exp_rd = refLoad(if_addr_m);
                checkOutput("if_rdata_fetch", 64'(bus.if_rdata), 64'(exp_rd));
                if_pend = 1'b0;
            end
        end

        checkOutput("mem_req_track", 64'(bus.mem_req), 64'(busy_now));
        checkOutput("busy_track", 64'(bus.busy), 64'(busy_now));
        if (exp_grant != 0) begin
            checkOutput("grant_addr", 64'(bus.mem_addr), 64'(exp_addr));
            checkOutput("grant_we", 64'(bus.mem_we), 64'(exp_we));
            checkOutput("grant_mask", 64'(bus.mem_mask), 64'(exp_mask));
            if (exp_grant == 2) checkOutput("grant_wdata", 64'(bus.mem_wdata), 64'(exp_wdata));
        end
        if (mem_wait_last) begin
            checkOutput("hold_addr", 64'(bus.mem_addr), 64'(cap_addr));
            checkOutput("hold_we", 64'(bus.mem_we), 64'(cap_we));
            checkOutput("hold_wdata", 64'(bus.mem_wdata), 64'(cap_wdata));
            checkOutput("hold_mask", 64'(bus.mem_mask), 64'(cap_mask));
        end

        // Memory model: random 0..3 wait states, random ack noise when idle.
        if (busy_now) begin
            if (exp_grant != 0) begin
                wait_left = $urandom_range(0, 3);
                cap_we    = exp_we;
                cap_addr  = exp_addr;
                cap_wdata = (exp_grant == 2) ? exp_wdata : bus.mem_wdata;
                cap_mask  = exp_mask;
            end
            if (wait_left == 0) begin
                ack = 1'b1;
                if (bus.mem_we) begin
                    ram[int'(bus.mem_addr[5:2])] = mergeMask(ramLoad(bus.mem_addr),
                                                             bus.mem_wdata, bus.mem_mask);
                    bus.mem_rdata = $urandom;
                end else begin
                    bus.mem_rdata = ramLoad(bus.mem_addr);
                end
            end else begin
                ack = 1'b0;
                wait_left--;
                bus.mem_rdata = $urandom;
            end
            mem_wait_last = !ack;
        end else begin
            ack = ($urandom_range(0, 3) == 0);
            bus.mem_rdata = $urandom;
            mem_wait_last = 1'b0;
        end
        bus.mem_ack = ack;

        // Requesters: hold a request until its valid; may reissue on the valid cycle.
        if (!d_pend && allow_new && ($urandom_range(0, 2) == 0)) begin
            d_pend    = 1'b1;
            d_we_m    = 1'($urandom_range(0, 1));
            d_addr_m  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            d_wdata_m = $urandom;
            d_mask_m  = 4'($urandom_range(1, 15));
        end
        if (!if_pend && allow_new && ($urandom_range(0, 1) == 0)) begin
            if_pend   = 1'b1;
            if_addr_m = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        end
        bus.d_req   = d_pend;
        bus.d_we    = d_pend ? d_we_m : 1'($urandom_range(0, 1));
        bus.d_addr  = d_pend ? d_addr_m : $urandom;
        bus.d_wdata = d_pend ? d_wdata_m : $urandom;
        bus.d_mask  = d_pend ? d_mask_m : 4'($urandom_range(0, 15));
        bus.if_req  = if_pend;
        bus.if_addr = if_pend ? if_addr_m : $urandom;

        // Grant rule for the coming edge: only from IDLE, data first, valid masks.
        exp_grant = 0;
        if (!busy_now) begin
            if (d_pend && !bus.d_valid) begin
                exp_grant = 2;
                exp_we    = d_we_m;
                exp_addr  = d_addr_m;
                exp_wdata = d_wdata_m;
                exp_mask  = d_mask_m;
            end else if (if_pend && !bus.if_valid) begin
                exp_grant = 1;
                exp_we    = 1'b0;
                exp_addr  = if_addr_m;
                exp_wdata = '0;
                exp_mask  = 4'hF;
            end
        end

        @(negedge clk);
    endtask

    initial begin
        int req_cycles;

        // Reset state.
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        checkOutput("rst_mem_req", 64'(bus.mem_req), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_if_valid", 64'(bus.if_valid), 64'd0);
        checkOutput("rst_d_valid", 64'(bus.d_valid), 64'd0);
        checkOutput("rst_if_rdata", 64'(bus.if_rdata), 64'd0);
        checkOutput("rst_d_rdata", 64'(bus.d_rdata), 64'd0);
        checkOutput("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        checkOutput("rst_mem_mask", 64'(bus.mem_mask), 64'd0);
        checkOutput("rst_errs", 64'({bus.if_err, bus.d_err}), 64'd0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single fetch with zero-wait memory.
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("f1_mem_req", 64'(bus.mem_req), 64'd1);
        checkOutput("f1_busy", 64'(bus.busy), 64'd1);
        checkOutput("f1_mem_addr", 64'(bus.mem_addr), 64'h100);
        checkOutput("f1_mem_we", 64'(bus.mem_we), 64'd0);
        checkOutput("f1_mem_mask", 64'(bus.mem_mask), 64'hF);
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 32'h0050_0093);
        checkOutput("f1_if_valid", 64'(bus.if_valid), 64'd1);
        checkOutput("f1_if_rdata", 64'(bus.if_rdata), 64'h0050_0093);
        checkOutput("f1_if_err", 64'(bus.if_err), 64'd0);
        checkOutput("f1_busy_off", 64'(bus.busy), 64'd0);
        checkOutput("f1_req_off", 64'(bus.mem_req), 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("f1_valid_pulse", 64'(bus.if_valid), 64'd0);
        checkOutput("f1_no_regrant", 64'(bus.mem_req), 64'd0);

        // Simultaneous requests: data served first, fetch right after.
        applyStimulus(1, 32'h100, 1, 0, 32'h2000, 0, 4'hF, 0, 0);
        checkOutput("s2_mem_addr_d", 64'(bus.mem_addr), 64'h2000);
        checkOutput("s2_mem_req", 64'(bus.mem_req), 64'd1);
        applyStimulus(1, 32'h100, 1, 0, 32'h2000, 0, 4'hF, 1, 32'hDEAD_BEEF);
        checkOutput("s2_d_valid", 64'(bus.d_valid), 64'd1);
        checkOutput("s2_d_rdata", 64'(bus.d_rdata), 64'hDEAD_BEEF);
        checkOutput("s2_if_not_yet", 64'(bus.if_valid), 64'd0);
        checkOutput("s2_req_gap", 64'(bus.mem_req), 64'd0);
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("s2_f_req", 64'(bus.mem_req), 64'd1);
        checkOutput("s2_f_addr", 64'(bus.mem_addr), 64'h100);
        checkOutput("s2_f_mask", 64'(bus.mem_mask), 64'hF);
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 32'h1357_9BDF);
        checkOutput("s2_if_valid", 64'(bus.if_valid), 64'd1);
        checkOutput("s2_if_rdata", 64'(bus.if_rdata), 64'h1357_9BDF);
        checkOutput("s2_d_quiet", 64'(bus.d_valid), 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Store with three wait states; requester inputs change mid-flight.
        applyStimulus(0, 0, 1, 1, 32'h40, 32'h1234_ABCD, 4'b0011, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            checkOutput("st_mem_req", 64'(bus.mem_req), 64'd1);
            checkOutput("st_mem_addr", 64'(bus.mem_addr), 64'h40);
            checkOutput("st_mem_we", 64'(bus.mem_we), 64'd1);
            checkOutput("st_mem_wdata", 64'(bus.mem_wdata), 64'h1234_ABCD);
            checkOutput("st_mem_mask", 64'(bus.mem_mask), 64'b0011);
            checkOutput("st_no_valid", 64'(bus.d_valid), 64'd0);
            if (k >= 2) applyStimulus(0, 0, 1, 0, 32'hFFC, 32'h0, 4'hF, (k == 4), 32'hBAD0_BAD0);
            else        applyStimulus(0, 0, 1, 1, 32'h40, 32'h1234_ABCD, 4'b0011, 0, 0);
        end
        checkOutput("st_d_valid", 64'(bus.d_valid), 64'd1);
        checkOutput("st_d_rdata_hold", 64'(bus.d_rdata), 64'hDEAD_BEEF);
        checkOutput("st_req_off", 64'(bus.mem_req), 64'd0);
        // Masking: d_req still high during the valid cycle.
        applyStimulus(0, 0, 1, 1, 32'h40, 32'h1234_ABCD, 4'b0011, 0, 0);
        checkOutput("mask_no_regrant", 64'(bus.mem_req), 64'd0);
        checkOutput("mask_single_pulse", 64'(bus.d_valid), 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mask_still_idle", 64'(bus.mem_req), 64'd0);

        // Reset during the second wait cycle of a fetch.
        applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rm_mem_req", 64'(bus.mem_req), 64'd1);
        applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rm_req_dropped", 64'(bus.mem_req), 64'd0);
        checkOutput("rm_busy", 64'(bus.busy), 64'd0);
        checkOutput("rm_no_valid", 64'({bus.if_valid, bus.d_valid}), 64'd0);
        checkOutput("rm_rdata", 64'({bus.if_rdata, bus.d_rdata}), 64'd0);
        checkOutput("rm_mem_bus", 64'({bus.mem_we, bus.mem_mask, bus.mem_addr}), 64'd0);
        checkOutput("rm_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rm_idle_after", 64'({bus.busy, bus.if_valid}), 64'd0);

        // Randomized traffic against the reference model.
        d_pend        = 1'b0;
        if_pend       = 1'b0;
        last_d_rdata  = '0;
        exp_grant     = 0;
        mem_wait_last = 1'b0;
        wait_left     = 0;
        for (int n = 0; n < 600; n++) randomCycle(1'b1);
        for (int n = 0; n < 40 && (d_pend || if_pend || mem_wait_last || exp_grant != 0); n++)
            randomCycle(1'b0);
        checkOutput("drain_complete", 64'({d_pend, if_pend}), 64'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Fetch whose memory never acknowledges.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
        req_cycles = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus.if_valid) break;
            if (bus.mem_req) req_cycles++;
            applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
        end
        checkOutput("to_if_valid", 64'(bus.if_valid), 64'd1);
        checkOutput("to_if_err", 64'(bus.if_err), 64'd1);
        checkOutput("to_if_rdata", 64'(bus.if_rdata), 64'h13);
        checkOutput("to_busy_cycles", 64'(req_cycles), 64'(TIMEOUT));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
`else
        req_cycles = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
